// File: rtl/gpio_in_cond_if.sv
// rtl/gpio_in_cond_if.sv - pad/config/event signal bundle for gpio_in_cond
// master drives pads and configuration; slave is the conditioning block.
interface gpio_in_cond_if #(
   parameter int NUM_PINS = 8,
   parameter int DB_CNT_W = 16
);
   logic [NUM_PINS-1:0]   pad_i;
   logic [NUM_PINS-1:0]   db_en_i;
   logic [DB_CNT_W-1:0]   db_period_i;
   logic [2*NUM_PINS-1:0] edge_mode_i;
   logic [NUM_PINS-1:0]   evt_clr_i;
   logic [NUM_PINS-1:0]   pin_o;
   logic [NUM_PINS-1:0]   evt_pulse_o;
   logic [NUM_PINS-1:0]   evt_o;
   logic                  irq_o;

   modport master (
      output pad_i, db_en_i, db_period_i, edge_mode_i, evt_clr_i,
      input  pin_o, evt_pulse_o, evt_o, irq_o
   );

   modport slave (
      input  pad_i, db_en_i, db_period_i, edge_mode_i, evt_clr_i,
      output pin_o, evt_pulse_o, evt_o, irq_o
   );
endinterface

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - per-pin synchroniser, debouncer, edge detector and sticky events
// Each pin runs its own STABLE/COUNT debounce FSM against the registered output level.
module gpio_in_cond #(
   parameter int NUM_PINS    = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT_W    = 16
) (
   input logic           clk,
   input logic           rst,
   gpio_in_cond_if.slave bus
);
   typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} state_e;

   logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
   logic [NUM_PINS-1:0] sync_s;
   state_e              state_q [NUM_PINS];
   state_e              state_d [NUM_PINS];
   logic [DB_CNT_W-1:0] cnt_q   [NUM_PINS];
   logic [DB_CNT_W-1:0] cnt_d   [NUM_PINS];
   logic [NUM_PINS-1:0] pin_q, pin_d;
   logic [NUM_PINS-1:0] pulse_q, pulse_d;
   logic [NUM_PINS-1:0] evt_q, evt_d;
   logic                period_zero;

   assign sync_s      = sync_q[SYNC_STAGES-1];
   assign period_zero = (bus.db_period_i == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= bus.pad_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   always_comb begin
      pin_d   = pin_q;
      pulse_d = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            STABLE: begin
               if (sync_s[i] != pin_q[i]) begin
                  if (!bus.db_en_i[i] || period_zero) begin
                     pin_d[i] = sync_s[i];
                  end else begin
                     state_d[i] = COUNT;
                     cnt_d[i]   = DB_CNT_W'(1);
                  end
               end
            end
            COUNT: begin
               // Disable and glitch both abandon the count without touching the level.
               if (!bus.db_en_i[i] || (sync_s[i] == pin_q[i])) begin
                  state_d[i] = STABLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] >= bus.db_period_i) begin
                  pin_d[i]   = sync_s[i];
                  state_d[i] = STABLE;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = STABLE;
               cnt_d[i]   = '0;
            end
         endcase
         pulse_d[i] = (pin_d[i] & ~pin_q[i] & bus.edge_mode_i[2*i])
                    | (~pin_d[i] & pin_q[i] & bus.edge_mode_i[2*i+1]);
      end
      // A new event outranks a clear issued in the same cycle.
      evt_d = (evt_q & ~bus.evt_clr_i) | pulse_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PINS; i++) begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
         end
         pin_q   <= '0;
         pulse_q <= '0;
         evt_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_PINS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         pin_q   <= pin_d;
         pulse_q <= pulse_d;
         evt_q   <= evt_d;
      end
   end

   assign bus.pin_o       = pin_q;
   assign bus.evt_pulse_o = pulse_q;
   assign bus.evt_o       = evt_q;
   assign bus.irq_o       = |evt_q;
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb/tb_gpio_in_cond.sv - scoreboard bench for gpio_in_cond
// Stimulus queues expected snapshots by cycle; the monitor checks them and flags stray pulses.
module tb_gpio_in_cond;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int         cyc;
      logic [7:0] pin;
      logic [7:0] pulse;
      logic [7:0] evt;
      logic       irq;
      string      name;
   } exp_t;

   exp_t sb_q[$];

   gpio_in_cond_if #(.NUM_PINS(8), .DB_CNT_W(16)) bus ();

   gpio_in_cond #(.NUM_PINS(8), .SYNC_STAGES(2), .DB_CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (bus.pin_o !== e.pin || bus.evt_pulse_o !== e.pulse ||
             bus.evt_o !== e.evt || bus.irq_o !== e.irq) begin
            failures++;
            $display("FAIL %s cyc=%0d got pin=%h pulse=%h evt=%h irq=%b want pin=%h pulse=%h evt=%h irq=%b",
                     e.name, cyc, bus.pin_o, bus.evt_pulse_o, bus.evt_o, bus.irq_o,
                     e.pin, e.pulse, e.evt, e.irq);
         end
      end else if (bus.evt_pulse_o !== 8'h00) begin
         checks++;
         failures++;
         $display("FAIL stray_pulse cyc=%0d got pulse=%h want pulse=00", cyc, bus.evt_pulse_o);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic expect_at(input int c, input logic [7:0] p, input logic [7:0] pu,
                            input logic [7:0] e, input logic irq, input string nm);
      exp_t x;
      x.cyc = c; x.pin = p; x.pulse = pu; x.evt = e; x.irq = irq; x.name = nm;
      sb_q.push_back(x);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.pad_i = '0; bus.db_en_i = '0; bus.db_period_i = '0;
      bus.edge_mode_i = '0; bus.evt_clr_i = '0;
      tick();
      tick();
      rst = 1'b0;
      expect_at(cyc, 8'h00, 8'h00, 8'h00, 1'b0, "reset_state");
   endtask

   initial begin
      int k, k2;
      bus.pad_i = '0; bus.db_en_i = '0; bus.db_period_i = '0;
      bus.edge_mode_i = '0; bus.evt_clr_i = '0;

      // Bypass: pin0 rising, no debounce
      do_reset();
      bus.edge_mode_i = 16'h0001;
      k = cyc; bus.pad_i = 8'h01;
      expect_at(k+2, 8'h00, 8'h00, 8'h00, 1'b0, "byp_pre");
      expect_at(k+3, 8'h01, 8'h01, 8'h01, 1'b1, "byp_edge");
      expect_at(k+4, 8'h01, 8'h00, 8'h01, 1'b1, "byp_hold");
      wait_until(k+6);

      // Debounce accept, both edges on pin1
      do_reset();
      bus.db_en_i = 8'h02; bus.db_period_i = 16'd5; bus.edge_mode_i = 16'h000C;
      k = cyc; bus.pad_i = 8'h02;
      expect_at(k+7, 8'h00, 8'h00, 8'h00, 1'b0, "db_rise_pre");
      expect_at(k+8, 8'h02, 8'h02, 8'h02, 1'b1, "db_rise");
      expect_at(k+9, 8'h02, 8'h00, 8'h02, 1'b1, "db_rise_after");
      wait_until(k+10);
      k2 = cyc; bus.pad_i = 8'h00; bus.evt_clr_i = 8'h02;
      expect_at(k2+1, 8'h02, 8'h00, 8'h00, 1'b0, "db_clear");
      tick();
      bus.evt_clr_i = 8'h00;
      expect_at(k2+7, 8'h02, 8'h00, 8'h00, 1'b0, "db_fall_pre");
      expect_at(k2+8, 8'h00, 8'h02, 8'h02, 1'b1, "db_fall");
      wait_until(k2+10);

      // Glitch reject on pin2, then a full-length accept proves the count restarted
      do_reset();
      bus.db_en_i = 8'h04; bus.db_period_i = 16'd5; bus.edge_mode_i = 16'h0030;
      k = cyc; bus.pad_i = 8'h04;
      wait_until(k+4);
      bus.pad_i = 8'h00;
      expect_at(k+12, 8'h00, 8'h00, 8'h00, 1'b0, "glitch_reject");
      wait_until(k+12);
      k2 = cyc; bus.pad_i = 8'h04;
      expect_at(k2+7, 8'h00, 8'h00, 8'h00, 1'b0, "glitch_recount_pre");
      expect_at(k2+8, 8'h04, 8'h04, 8'h04, 1'b1, "glitch_recount");
      wait_until(k2+10);

      // Set/clear collision on pin3; pin4 in mode 00 must not pulse
      do_reset();
      bus.edge_mode_i = 16'h0040;
      k = cyc; bus.pad_i = 8'h18; bus.evt_clr_i = 8'h08;
      expect_at(k+2, 8'h00, 8'h00, 8'h00, 1'b0, "coll_pre");
      expect_at(k+3, 8'h18, 8'h08, 8'h08, 1'b1, "coll_set_wins");
      expect_at(k+4, 8'h18, 8'h00, 8'h00, 1'b0, "coll_cleared");
      wait_until(k+5);
      bus.evt_clr_i = 8'h00;

      // Period reduced mid-count
      do_reset();
      bus.db_en_i = 8'h01; bus.db_period_i = 16'd10; bus.edge_mode_i = 16'h0001;
      k = cyc; bus.pad_i = 8'h01;
      wait_until(k+6);
      bus.db_period_i = 16'd2;
      expect_at(k+6, 8'h00, 8'h00, 8'h00, 1'b0, "per_drop_pre");
      expect_at(k+7, 8'h01, 8'h01, 8'h01, 1'b1, "per_drop");
      wait_until(k+9);

      // Debounce disabled mid-count
      do_reset();
      bus.db_en_i = 8'h01; bus.db_period_i = 16'd10; bus.edge_mode_i = 16'h0001;
      k = cyc; bus.pad_i = 8'h01;
      wait_until(k+5);
      bus.db_en_i = 8'h00;
      expect_at(k+6, 8'h00, 8'h00, 8'h00, 1'b0, "dis_pre");
      expect_at(k+7, 8'h01, 8'h01, 8'h01, 1'b1, "dis_follow");
      wait_until(k+9);

      // All pins at once, then reset during COUNT with pad high across release
      do_reset();
      bus.edge_mode_i = 16'h5555;
      k = cyc; bus.pad_i = 8'hFF;
      expect_at(k+3, 8'hFF, 8'hFF, 8'hFF, 1'b1, "all_pins");
      wait_until(k+4);
      bus.db_en_i = 8'hFF; bus.db_period_i = 16'd4; bus.pad_i = 8'h00;
      expect_at(k+8, 8'hFF, 8'h00, 8'hFF, 1'b1, "rst_counting");
      wait_until(k+8);
      rst = 1'b1; bus.pad_i = 8'hFF;
      expect_at(k+9, 8'h00, 8'h00, 8'h00, 1'b0, "rst_mid");
      tick();
      rst = 1'b0;
      expect_at(k+15, 8'h00, 8'h00, 8'h00, 1'b0, "rst_rise_pre");
      expect_at(k+16, 8'hFF, 8'hFF, 8'hFF, 1'b1, "rst_rise");
      wait_until(k+18);

      for (int t = 0; t < 20 && sb_q.size() > 0; t++) tick();
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         failures++;
         $display("FAIL timeout_%s got no check at cyc=%0d want checked", e.name, e.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
